// File: rtl/hazard_unit.sv
// Pipeline hazard controller: EX operand forwarding, load-use stall and branch flush.
// Optional saturating stall/flush performance counters are built when HAZARD_PERF_EN is defined.
module hazard_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int PERF_CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] Rs1_D,
   input  logic [REG_ADDR_W-1:0] Rs2_D,
   input  logic [REG_ADDR_W-1:0] Rs1_E,
   input  logic [REG_ADDR_W-1:0] Rs2_E,
   input  logic [REG_ADDR_W-1:0] Rd_E,
   input  logic                  RegWrite_E,
   input  logic                  MemRead_E,
   input  logic                  PCSrc_E,
   output logic [1:0]            ForwardA_E,
   output logic [1:0]            ForwardB_E,
   output logic                  Stall_F,
   output logic                  Stall_D,
   output logic                  Flush_D,
   output logic                  Flush_E,
   output logic [PERF_CNT_W-1:0] StallCount,
   output logic [PERF_CNT_W-1:0] FlushCount
);

   logic [REG_ADDR_W-1:0] rd_m_q, rd_w_q;
   logic                  regwrite_m_q, regwrite_w_q;
   logic                  lw_stall;

   // Shadow copy of the E->M->W destination fields; bubbles arrive already zeroed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_m_q       <= '0;
         regwrite_m_q <= 1'b0;
         rd_w_q       <= '0;
         regwrite_w_q <= 1'b0;
      end else begin
         rd_m_q       <= Rd_E;
         regwrite_m_q <= RegWrite_E;
         rd_w_q       <= rd_m_q;
         regwrite_w_q <= regwrite_m_q;
      end
   end

   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
      if (regwrite_m_q && (rd_m_q != '0) && (rd_m_q == rs))
         return 2'b10;
      else if (regwrite_w_q && (rd_w_q != '0) && (rd_w_q == rs))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign ForwardA_E = fwd_sel(Rs1_E);
   assign ForwardB_E = fwd_sel(Rs2_E);

   assign lw_stall = MemRead_E && (Rd_E != '0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

   // A taken branch squashes the D instruction, so holding it would be pointless.
   assign Stall_F = lw_stall && !PCSrc_E;
   assign Stall_D = lw_stall && !PCSrc_E;
   assign Flush_D = PCSrc_E;
   assign Flush_E = lw_stall || PCSrc_E;

`ifdef HAZARD_PERF_EN
   localparam logic [PERF_CNT_W-1:0] CNT_ONE = {{(PERF_CNT_W-1){1'b0}}, 1'b1};

   logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (Stall_D && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (Flush_D && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign StallCount = stall_cnt_q;
   assign FlushCount = flush_cnt_q;
`else
   assign StallCount = '0;
   assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vectors, a history-based reference model checked every cycle,
// plus literal expectations for the documented scenarios (counter width reduced to test saturation).
module tb_hazard_unit;

   localparam int AW  = 5;
   localparam int CW  = 3;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] Rs1_D = '0, Rs2_D = '0, Rs1_E = '0, Rs2_E = '0, Rd_E = '0;
   logic          RegWrite_E = 1'b0, MemRead_E = 1'b0, PCSrc_E = 1'b0;
   logic [1:0]    ForwardA_E, ForwardB_E;
   logic          Stall_F, Stall_D, Flush_D, Flush_E;
   logic [CW-1:0] StallCount, FlushCount;

   int checks = 0;
   int failures = 0;
   bit done = 1'b0;

   hazard_unit #(.REG_ADDR_W(AW), .PERF_CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
      .RegWrite_E(RegWrite_E), .MemRead_E(MemRead_E), .PCSrc_E(PCSrc_E),
      .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
      .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D), .Flush_E(Flush_E),
      .StallCount(StallCount), .FlushCount(FlushCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: remembers what the E stage wrote one and two cycles back.
   int hist_rd[1:2] = '{0, 0};
   bit hist_we[1:2] = '{0, 0};
   int exp_sc = 0;
   int exp_fc = 0;

   function automatic int exp_fwd(input int rs);
      int sel = 0;
      if (rs != 0) begin
         if (hist_we[1] && hist_rd[1] == rs) sel = 2;
         else if (hist_we[2] && hist_rd[2] == rs) sel = 1;
      end
      return sel;
   endfunction

   always @(negedge clk) begin
      bit load_hit, stall, flush_e;
      int fa, fb, sc, fc;
      if (!done) begin
         load_hit = MemRead_E && Rd_E != 0 && (Rd_E == Rs1_D || Rd_E == Rs2_D);
         stall    = load_hit && !PCSrc_E;
         flush_e  = load_hit || PCSrc_E;
         fa = rst_n ? exp_fwd(int'(Rs1_E)) : 0;
         fb = rst_n ? exp_fwd(int'(Rs2_E)) : 0;
`ifdef HAZARD_PERF_EN
         sc = rst_n ? exp_sc : 0;
         fc = rst_n ? exp_fc : 0;
`else
         sc = 0;
         fc = 0;
`endif
         chk("model_fwdA",  int'(ForwardA_E), fa);
         chk("model_fwdB",  int'(ForwardB_E), fb);
         chk("model_stallF", int'(Stall_F), int'(stall));
         chk("model_stallD", int'(Stall_D), int'(stall));
         chk("model_flushD", int'(Flush_D), int'(PCSrc_E));
         chk("model_flushE", int'(Flush_E), int'(flush_e));
         chk("model_stallcnt", int'(StallCount), sc);
         chk("model_flushcnt", int'(FlushCount), fc);
         // Advance the model to the state the next rising edge produces.
         if (!rst_n) begin
            hist_rd = '{0, 0};
            hist_we = '{0, 0};
            exp_sc = 0;
            exp_fc = 0;
         end else begin
            hist_rd[2] = hist_rd[1];
            hist_we[2] = hist_we[1];
            hist_rd[1] = int'(Rd_E);
            hist_we[1] = RegWrite_E;
            if (stall && exp_sc < CMAX) exp_sc++;
            if (PCSrc_E && exp_fc < CMAX) exp_fc++;
         end
      end
   end

   task automatic cyc(input bit rst, input int rs1d, input int rs2d, input int rs1e, input int rs2e,
                      input int rde, input bit rwe, input bit mre, input bit pcs);
      @(posedge clk);
      #1;
      rst_n = rst; Rs1_D = AW'(rs1d); Rs2_D = AW'(rs2d); Rs1_E = AW'(rs1e); Rs2_E = AW'(rs2e);
      Rd_E = AW'(rde); RegWrite_E = rwe; MemRead_E = mre; PCSrc_E = pcs;
      @(negedge clk);
      #1;
   endtask

   function automatic int cnt_exp(input int v);
`ifdef HAZARD_PERF_EN
      return v;
`else
      return 0;
`endif
   endfunction

   initial begin
      // Reset with arbitrary activity on the inputs.
      cyc(0, 8, 0, 0, 0, 5, 1, 0, 0);
      cyc(0, 0, 0, 5, 5, 5, 1, 0, 0);
      chk("rst_fwdA", int'(ForwardA_E), 0);
      chk("rst_fwdB", int'(ForwardB_E), 0);
      chk("rst_stallcnt", int'(StallCount), 0);
      chk("rst_flushcnt", int'(FlushCount), 0);

      // Forwarding scenarios.
      cyc(1, 0, 0, 0, 0, 5, 1, 0, 0);
      cyc(1, 0, 0, 5, 0, 6, 1, 0, 0);
      chk("mem_fwdA", int'(ForwardA_E), 2);
      chk("mem_fwdB", int'(ForwardB_E), 0);
      cyc(1, 0, 0, 0, 0, 7, 1, 0, 0);
      cyc(1, 0, 0, 0, 6, 7, 1, 0, 0);
      chk("wb_fwdB", int'(ForwardB_E), 1);
      cyc(1, 0, 0, 7, 0, 0, 1, 0, 0);
      chk("prio_fwdA", int'(ForwardA_E), 2);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("x0_fwdA", int'(ForwardA_E), 0);

      // Load-use stall, bubble, then WB forward to the consumer.
      cyc(1, 0, 8, 0, 0, 8, 1, 1, 0);
      chk("lu_stallF", int'(Stall_F), 1);
      chk("lu_stallD", int'(Stall_D), 1);
      chk("lu_flushE", int'(Flush_E), 1);
      chk("lu_flushD", int'(Flush_D), 0);
      cyc(1, 0, 8, 0, 0, 0, 0, 0, 0);
      chk("bubble_stallD", int'(Stall_D), 0);
      chk("bubble_flushE", int'(Flush_E), 0);
      cyc(1, 0, 0, 0, 8, 0, 0, 0, 0);
      chk("lu_fwdB", int'(ForwardB_E), 1);

      // Taken branch together with a load-use condition.
      cyc(1, 9, 0, 0, 0, 9, 1, 1, 1);
      chk("br_flushD", int'(Flush_D), 1);
      chk("br_flushE", int'(Flush_E), 1);
      chk("br_stallF", int'(Stall_F), 0);
      chk("br_stallD", int'(Stall_D), 0);

      // Short burst of random traffic, checked by the model only.
      for (int i = 0; i < 24; i++)
         cyc(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));

      // Reset mid-operation drops tracking immediately.
      cyc(1, 0, 0, 0, 0, 10, 1, 0, 0);
      cyc(0, 0, 0, 10, 10, 0, 0, 0, 0);
      chk("midrst_fwdA", int'(ForwardA_E), 0);
      chk("midrst_fwdB", int'(ForwardB_E), 0);
      chk("midrst_stallcnt", int'(StallCount), 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

      // Three load-use stalls and two taken branches.
      for (int i = 0; i < 3; i++) begin
         cyc(1, 3, 0, 0, 0, 3, 1, 1, 0);
         cyc(1, 3, 0, 0, 0, 0, 0, 0, 0);
      end
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("perf_stallcnt", int'(StallCount), cnt_exp(3));
      chk("perf_flushcnt", int'(FlushCount), cnt_exp(2));

      // Drive the stall counter to all-ones, then one more stall must not wrap.
      for (int i = 0; i < CMAX - 3; i++) begin
         cyc(1, 0, 4, 0, 0, 4, 1, 1, 0);
         cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      chk("sat_full", int'(StallCount), cnt_exp(CMAX));
      cyc(1, 0, 4, 0, 0, 4, 1, 1, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("sat_hold", int'(StallCount), cnt_exp(CMAX));

      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
